// File: rtl/demux_pkg.sv
// Shared types and widths for the 1-to-8 serial demultiplexer/deserializer.
package demux_pkg;
    localparam int WORD_W = 8;
    localparam int IDX_W  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;
endpackage

// File: rtl/demux1to8_dec.sv
// 3-to-8 one-hot decoder with enable; drives the capture/mask write strobe.
module demux1to8_dec
    import demux_pkg::*;
(
    input  logic [IDX_W-1:0]  idx,
    input  logic              en,
    output logic [WORD_W-1:0] strobe
);
    always_comb begin
        strobe = '0;
        if (en) strobe[idx] = 1'b1;
    end
endmodule

// File: rtl/demux1to8_deser.sv
// Registered 1-to-8 demultiplexer: rebuilds a word from a serial bit stream,
// indexed explicitly by {s2,s1,s0} or by an internal counter, with valid/ready output.
module demux1to8_deser
    import demux_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              s0,
    input  logic              s1,
    input  logic              s2,
    input  logic              addr_mode,
    output logic [WORD_W-1:0] o,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              overrun
);
    state_t              state;
    logic [WORD_W-1:0]   cap;
    logic [WORD_W-1:0]   mask;
    logic [WORD_W-1:0]   strobe;
    logic [WORD_W-1:0]   cap_next;
    logic [IDX_W-1:0]    cnt;
    logic [IDX_W-1:0]    auto_idx;
    logic [IDX_W-1:0]    idx;
    logic                mode_q;
    logic                mode_eff;
    logic                frame_start;
    logic                acc;
    logic                complete;

    assign in_ready    = (state != HOLD) || word_ready;
    assign acc         = in_valid && in_ready;
    assign frame_start = (mask == '0);

    // The first bit of a frame uses the live addr_mode; later bits use the latched copy.
    assign mode_eff = frame_start ? addr_mode : mode_q;
    assign auto_idx = LSB_FIRST ? cnt : (IDX_W'(WORD_W - 1) - cnt);
    assign idx      = mode_eff ? {s2, s1, s0} : auto_idx;

    demux1to8_dec u_dec (
        .idx    (idx),
        .en     (acc),
        .strobe (strobe)
    );

    assign cap_next = (cap & ~strobe) | (strobe & {WORD_W{i}});
    // A rewrite of an already-filled index leaves mask unchanged, so it cannot complete a word.
    assign complete = acc && ((mask | strobe) == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cap        <= '0;
            mask       <= '0;
            cnt        <= '0;
            mode_q     <= 1'b0;
            o          <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (in_valid && !in_ready) overrun <= 1'b1;

            if (acc) begin
                cap <= cap_next;
                if (frame_start) mode_q <= addr_mode;
                if (complete) begin
                    o          <= cap_next;
                    word_valid <= 1'b1;
                    mask       <= '0;
                    cnt        <= '0;
                    state      <= HOLD;
                end else begin
                    // Accepting in HOLD implies word_ready, so the pending word is consumed here.
                    word_valid <= 1'b0;
                    mask       <= mask | strobe;
                    cnt        <= cnt + 1'b1;
                    state      <= COLLECT;
                end
            end else if (state == HOLD && word_ready) begin
                word_valid <= 1'b0;
                state      <= IDLE;
            end
        end
    end
endmodule
